// File: rtl/apb_master_pkg.sv
// Shared types for the command-queued APB3 requester.
// Command fields are sized by CMD_ADDR_W / CMD_DATA_W (the widest supported).
package apb_master_pkg;

    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_INC   = 2'b11
    } apb_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_t;

    typedef struct packed {
        apb_op_t                 op;
        logic [CMD_ADDR_W-1:0]   addr;
        logic [CMD_DATA_W-1:0]   wdata;
    } cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is read combinationally.
// DEPTH must be a power of two, at least 2.
module apb_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/apb_cmd_master.sv
// Command-queued APB3 requester: READ / WRITE / INC through a FIFO.
// Define APB_TIMEOUT_EN to bound ACCESS waits to TIMEOUT cycles.
module apb_cmd_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_W    = CMD_ADDR_W,
    parameter int DATA_W    = CMD_DATA_W,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              pwrite_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic              pready_i,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pslverr_i
);

    localparam int CW = $clog2(CMD_DEPTH);

    cmd_t       cmd_in;
    cmd_t       cmd_head;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [CW:0] fifo_count;
    logic       ready_q;
    apb_state_t state;
    logic       phase;
    apb_op_t    op_q;
    logic       timed_out;

    always_comb begin
        cmd_in                    = '0;
        cmd_in.op                 = apb_op_t'(cmd_op_i);
        cmd_in.addr[ADDR_W-1:0]   = cmd_addr_i;
        cmd_in.wdata[DATA_W-1:0]  = cmd_wdata_i;
    end

    assign cmd_ready_o = ready_q & ~fifo_full;
    assign push = cmd_valid_i & cmd_ready_o &
                  (cmd_op_i != OP_NOP);
    assign pop  = (state == ST_IDLE) & ~fifo_empty;

    apb_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (cmd_in),
        .pop     (pop),
        .rd_data (cmd_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign psel_o    = (state == ST_SETUP) |
                       (state == ST_ACCESS);
    assign penable_o = (state == ST_ACCESS);
    assign busy_o    = (fifo_count != '0) |
                       (state != ST_IDLE);

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tcnt <= '0;
        else if (state == ST_SETUP)
            tcnt <= '0;
        else if (state == ST_ACCESS && !pready_i)
            tcnt <= tcnt + TW'(1);
    end

    // The cycle that would bring the count to TIMEOUT ends the transfer.
    assign timed_out = (state == ST_ACCESS) & ~pready_i &
                       (tcnt == TW'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            phase       <= 1'b0;
            op_q        <= OP_NOP;
            ready_q     <= 1'b0;
            paddr_o     <= '0;
            pwrite_o    <= 1'b0;
            pwdata_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            ready_q     <= 1'b1;
            rsp_valid_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state    <= ST_SETUP;
                        phase    <= 1'b0;
                        op_q     <= cmd_head.op;
                        paddr_o  <= cmd_head.addr[ADDR_W-1:0];
                        pwrite_o <= (cmd_head.op == OP_WRITE);
                        pwdata_o <= (cmd_head.op == OP_WRITE) ?
                                    cmd_head.wdata[DATA_W-1:0] : '0;
                    end
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (timed_out) begin
                        state       <= ST_IDLE;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= '0;
                        rsp_err_o   <= 1'b1;
                    end else if (pready_i) begin
                        if (op_q == OP_INC && !phase && !pslverr_i) begin
                            // Re-enter SETUP for the write-back, same address.
                            state    <= ST_SETUP;
                            phase    <= 1'b1;
                            pwrite_o <= 1'b1;
                            pwdata_o <= prdata_i + DATA_W'(1);
                        end else begin
                            state       <= ST_IDLE;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= pslverr_i;
                            rsp_data_o  <= (op_q == OP_WRITE || phase) ?
                                           pwdata_o : prdata_i;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a small wait-state APB slave.
// Build with APB_TIMEOUT_EN to exercise the ACCESS timeout.
module tb_apb_cmd_master;
    import apb_master_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i = 2'b00;
    logic [31:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        psel_o;
    logic        penable_o;
    logic [31:0] paddr_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic        pready_i;
    logic [31:0] prdata_i;
    logic        pslverr_i;

    int          n_tests = 0;
    int          n_fail = 0;

    int          wait_cfg = 0;
    logic        err_cfg = 1'b0;
    logic        never_ready = 1'b0;
    logic [31:0] rd_value = '0;
    int          wcnt = 0;

    int          m_rsp = 0;
    int          m_psel = 0;
    int          m_pen = 0;
    int          m_rise = 0;
    int          m_wr = 0;
    logic        psel_d = 1'b0;
    logic [31:0] rsp_d [64];
    logic        rsp_e [64];
    logic [31:0] wr_a [64];
    logic [31:0] wr_d [64];

    apb_cmd_master #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .CMD_DEPTH (4),
        .TIMEOUT   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .paddr_o     (paddr_o),
        .pwrite_o    (pwrite_o),
        .pwdata_o    (pwdata_o),
        .pready_i    (pready_i),
        .prdata_i    (prdata_i),
        .pslverr_i   (pslverr_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (psel_o && !penable_o)
            wcnt <= 0;
        else if (psel_o && penable_o && !pready_i)
            wcnt <= wcnt + 1;
    end

    always_comb begin
        pready_i  = psel_o & penable_o & ~never_ready &
                    (wcnt >= wait_cfg);
        pslverr_i = pready_i & err_cfg;
    end
    assign prdata_i = rd_value;

    always @(negedge clk) begin
        psel_d <= psel_o;
        if (psel_o)
            m_psel <= m_psel + 1;
        if (psel_o && !psel_d)
            m_rise <= m_rise + 1;
        if (penable_o)
            m_pen <= m_pen + 1;
        if (psel_o && penable_o && pready_i && pwrite_o) begin
            wr_a[m_wr % 64] <= paddr_o;
            wr_d[m_wr % 64] <= pwdata_o;
            m_wr <= m_wr + 1;
        end
        if (rsp_valid_o) begin
            rsp_d[m_rsp % 64] <= rsp_data_o;
            rsp_e[m_rsp % 64] <= rsp_err_o;
            m_rsp <= m_rsp + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op,
                            input logic [31:0] a,
                            input logic [31:0] d);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        for (int i = 0; i < 100 && !cmd_ready_o; i++)
            tick();
        if (!cmd_ready_o) begin
            n_tests++; n_fail++;
            $display("FAIL send_ready got 0 required 1");
        end
        tick();
    endtask

    task automatic wait_rsp(input string nm, input int target);
        for (int i = 0; i < 400 && m_rsp < target; i++)
            tick();
        n_tests++;
        if (m_rsp < target) begin
            n_fail++;
            $display("FAIL %s rsp_count got %0d required %0d",
                     nm, m_rsp, target);
        end
        tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_tests++;
        if ({cmd_ready_o, rsp_valid_o, busy_o, psel_o, penable_o,
             pwrite_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b required 000000",
                     {cmd_ready_o, rsp_valid_o, busy_o, psel_o,
                      penable_o, pwrite_o});
        end
        n_tests++;
        if ({paddr_o, pwdata_o, rsp_data_o, rsp_err_o} !== 97'b0) begin
            n_fail++;
            $display("FAIL reset_data got %h required 0",
                     {paddr_o, pwdata_o, rsp_data_o, rsp_err_o});
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (cmd_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_release got %b required 0", cmd_ready_o);
        end
        tick();
        n_tests++;
        if (cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_rise got %b required 1", cmd_ready_o);
        end
    endtask

    task automatic test_read();
        int b_rsp, b_psel, b_pen;
        rd_value = 32'h1234_5678; wait_cfg = 0; err_cfg = 1'b0;
        b_rsp = m_rsp; b_psel = m_psel; b_pen = m_pen;
        send_cmd(OP_READ, 32'hDEAD_CAFE, 32'h0);
        cmd_valid_i = 1'b0;
        n_tests++;
        if (psel_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_idle psel/busy got %b%b required 01",
                     psel_o, busy_o);
        end
        tick();
        n_tests++;
        if ({psel_o, penable_o} !== 2'b10 || paddr_o !== 32'hDEAD_CAFE) begin
            n_fail++;
            $display("FAIL rd_setup got %b %h required 10 deadcafe",
                     {psel_o, penable_o}, paddr_o);
        end
        tick();
        n_tests++;
        if ({psel_o, penable_o, pwrite_o} !== 3'b110) begin
            n_fail++;
            $display("FAIL rd_access got %b required 110",
                     {psel_o, penable_o, pwrite_o});
        end
        tick();
        n_tests++;
        if ({rsp_valid_o, rsp_err_o, psel_o} !== 3'b100 ||
            rsp_data_o !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL rd_rsp got %b %h required 100 12345678",
                     {rsp_valid_o, rsp_err_o, psel_o}, rsp_data_o);
        end
        tick();
        n_tests++;
        if (m_psel - b_psel != 2 || m_pen - b_pen != 1 ||
            m_rsp - b_rsp != 1) begin
            n_fail++;
            $display("FAIL rd_counts got %0d %0d %0d required 2 1 1",
                     m_psel - b_psel, m_pen - b_pen, m_rsp - b_rsp);
        end
    endtask

    task automatic test_inc_wrap();
        int b_rsp, b_psel, b_pen, b_rise, b_wr;
        rd_value = 32'hFFFF_FFFF; wait_cfg = 2; err_cfg = 1'b0;
        b_rsp = m_rsp; b_psel = m_psel; b_pen = m_pen;
        b_rise = m_rise; b_wr = m_wr;
        send_cmd(OP_INC, 32'h0000_0100, 32'h0);
        cmd_valid_i = 1'b0;
        wait_rsp("inc_wrap", b_rsp + 1);
        n_tests++;
        if (rsp_d[b_rsp % 64] !== 32'h0 || rsp_e[b_rsp % 64] !== 1'b0) begin
            n_fail++;
            $display("FAIL inc_rsp got %h %b required 00000000 0",
                     rsp_d[b_rsp % 64], rsp_e[b_rsp % 64]);
        end
        n_tests++;
        if (m_wr - b_wr != 1 || wr_a[b_wr % 64] !== 32'h100 ||
            wr_d[b_wr % 64] !== 32'h0) begin
            n_fail++;
            $display("FAIL inc_write got %0d %h %h required 1 100 0",
                     m_wr - b_wr, wr_a[b_wr % 64], wr_d[b_wr % 64]);
        end
        n_tests++;
        if (m_rise - b_rise != 1 || m_psel - b_psel != 8 ||
            m_pen - b_pen != 6) begin
            n_fail++;
            $display("FAIL inc_phases got %0d %0d %0d required 1 8 6",
                     m_rise - b_rise, m_psel - b_psel, m_pen - b_pen);
        end
    endtask

    task automatic test_inc_err();
        int b_rsp, b_psel, b_wr;
        rd_value = 32'h0000_0055; wait_cfg = 0; err_cfg = 1'b1;
        b_rsp = m_rsp; b_psel = m_psel; b_wr = m_wr;
        send_cmd(OP_INC, 32'h0000_0200, 32'h0);
        cmd_valid_i = 1'b0;
        wait_rsp("inc_err", b_rsp + 1);
        err_cfg = 1'b0;
        n_tests++;
        if (rsp_d[b_rsp % 64] !== 32'h55 || rsp_e[b_rsp % 64] !== 1'b1) begin
            n_fail++;
            $display("FAIL inc_err_rsp got %h %b required 00000055 1",
                     rsp_d[b_rsp % 64], rsp_e[b_rsp % 64]);
        end
        n_tests++;
        if (m_wr - b_wr != 0 || m_psel - b_psel != 2) begin
            n_fail++;
            $display("FAIL inc_err_nowrite got %0d %0d required 0 2",
                     m_wr - b_wr, m_psel - b_psel);
        end
    endtask

    task automatic test_nop();
        int b_rsp, b_psel;
        b_rsp = m_rsp; b_psel = m_psel;
        send_cmd(OP_NOP, 32'h40, 32'h1);
        cmd_valid_i = 1'b0;
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_busy got %b required 0", busy_o);
        end
        repeat (5) tick();
        n_tests++;
        if (m_rsp - b_rsp != 0 || m_psel - b_psel != 0) begin
            n_fail++;
            $display("FAIL nop_quiet got %0d %0d required 0 0",
                     m_rsp - b_rsp, m_psel - b_psel);
        end
    endtask

    task automatic test_back_to_back();
        int b_rsp, b_wr;
        wait_cfg = 10; rd_value = 32'h0;
        b_rsp = m_rsp; b_wr = m_wr;
        for (int i = 0; i < 5; i++)
            send_cmd(OP_WRITE, 32'h10 * i, 32'hA0 + i);
        cmd_valid_i = 1'b0;
        n_tests++;
        if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_full ready/busy got %b%b required 01",
                     cmd_ready_o, busy_o);
        end
        wait_rsp("b2b", b_rsp + 5);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (rsp_d[(b_rsp + i) % 64] !== 32'hA0 + i ||
                rsp_e[(b_rsp + i) % 64] !== 1'b0 ||
                wr_a[(b_wr + i) % 64] !== 32'h10 * i) begin
                n_fail++;
                $display("FAIL b2b_order[%0d] got %h %b %h required %h 0 %h",
                         i, rsp_d[(b_rsp + i) % 64],
                         rsp_e[(b_rsp + i) % 64],
                         wr_a[(b_wr + i) % 64], 32'hA0 + i, 32'h10 * i);
            end
        end
        n_tests++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain ready/busy got %b%b required 10",
                     cmd_ready_o, busy_o);
        end
        wait_cfg = 0;
    endtask

    task automatic test_timeout();
        int b_rsp, b_pen;
        rd_value = 32'h0BAD_F00D; wait_cfg = 0; never_ready = 1'b1;
        b_rsp = m_rsp; b_pen = m_pen;
        send_cmd(OP_READ, 32'h300, 32'h0);
        cmd_valid_i = 1'b0;
`ifdef APB_TIMEOUT_EN
        wait_rsp("timeout", b_rsp + 1);
        never_ready = 1'b0;
        n_tests++;
        if (rsp_d[b_rsp % 64] !== 32'h0 || rsp_e[b_rsp % 64] !== 1'b1) begin
            n_fail++;
            $display("FAIL to_rsp got %h %b required 00000000 1",
                     rsp_d[b_rsp % 64], rsp_e[b_rsp % 64]);
        end
        n_tests++;
        if (m_pen - b_pen != 16 || psel_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL to_access got %0d %b %b required 16 0 0",
                     m_pen - b_pen, psel_o, busy_o);
        end
`else
        repeat (40) tick();
        n_tests++;
        if (m_rsp - b_rsp != 0 || penable_o !== 1'b1) begin
            n_fail++;
            $display("FAIL nto_wait got %0d %b required 0 1",
                     m_rsp - b_rsp, penable_o);
        end
        never_ready = 1'b0;
        wait_rsp("nto", b_rsp + 1);
        n_tests++;
        if (rsp_d[b_rsp % 64] !== 32'h0BAD_F00D ||
            rsp_e[b_rsp % 64] !== 1'b0) begin
            n_fail++;
            $display("FAIL nto_rsp got %h %b required 0badf00d 0",
                     rsp_d[b_rsp % 64], rsp_e[b_rsp % 64]);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int b_rsp, b_psel;
        wait_cfg = 10;
        for (int i = 0; i < 3; i++)
            send_cmd(OP_READ, 32'h500 + i, 32'h0);
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 20 && !penable_o; i++)
            tick();
        n_tests++;
        if (penable_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_access got %b required 1", penable_o);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({psel_o, penable_o, busy_o, cmd_ready_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL mid_reset got %b required 0000",
                     {psel_o, penable_o, busy_o, cmd_ready_o});
        end
        repeat (2) tick();
        reset = 1'b0;
        b_rsp = m_rsp; b_psel = m_psel;
        repeat (20) tick();
        n_tests++;
        if (m_rsp - b_rsp != 0 || m_psel - b_psel != 0 ||
            busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_after got %0d %0d %b %b required 0 0 0 1",
                     m_rsp - b_rsp, m_psel - b_psel, busy_o, cmd_ready_o);
        end
        wait_cfg = 0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_inc_wrap();
        test_inc_err();
        test_nop();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Parametrised, command-queued APB3 requester. Successor to the fixed-address, fixed-width single-command master.
- Accepts READ / WRITE / INCREMENT (read-modify-write) commands with arbitrary address through a valid/ready port, buffering them in a small FIFO.
- Drives one APB transfer sequence per command and returns one response per command.
- Sits between a local controller/bench and an APB peripheral or arbiter.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- CMD_DEPTH, 4, command FIFO depth; power of two, at least 2.
- TIMEOUT, 16, maximum ACCESS wait cycles (used only with APB_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  FIFO not full
- cmd_op_i  in  2  00 NOP, 01 READ, 10 WRITE, 11 INC
- cmd_addr_i  in  ADDR_W  target address
- cmd_wdata_i  in  DATA_W  write data (WRITE only)
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_data_o  out  DATA_W  read data (READ); value written (WRITE, INC)
- rsp_err_o  out  1  slave error or timeout
- busy_o  out  1  FIFO non-empty or FSM not IDLE
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- paddr_o  out  ADDR_W  APB address
- pwrite_o  out  1  APB direction
- pwdata_o  out  DATA_W  APB write data
- pready_i  in  1  APB ready
- prdata_i  in  DATA_W  APB read data
- pslverr_i  in  1  APB slave error

Behaviour:
- Reset: all outputs 0; FSM IDLE; FIFO empty. cmd_ready_o rises the first cycle after reset deasserts.
- Command acceptance:
  - Accept on cmd_valid_i & cmd_ready_o.
  - Simultaneous push and pop while full is not allowed: ready is computed from the registered count.
  - NOP is accepted but never enqueued and produces no response.
- FSM states: IDLE, SETUP, ACCESS, plus a registered phase bit (0 = read phase, 1 = write phase of INC).
  - IDLE -> SETUP when the FIFO is non-empty; pop the head into the command register.
  - SETUP -> ACCESS unconditionally.
  - ACCESS holds while pready_i = 0.
- Address and data:
  - paddr_o / pwrite_o / pwdata_o are registered and stable from SETUP through the end of ACCESS.
  - psel_o = SETUP | ACCESS; penable_o = ACCESS.
  - pwrite_o = 1 for WRITE and for the INC write phase.
- Transfer completion (ACCESS & pready_i):
  - READ or WRITE: rsp_valid_o next cycle; rsp_data_o = prdata_i (READ) or write data (WRITE); rsp_err_o = pslverr_i sampled at completion. FSM -> IDLE.
  - INC, read phase, no error: capture prdata_i + 1, truncated modulo 2^DATA_W (so all-ones wraps to 0). Set phase = 1 and go directly to SETUP with the same address; no IDLE cycle.
  - INC, read phase, pslverr_i = 1: write phase skipped; response with rsp_err_o = 1 and rsp_data_o = prdata_i.
  - INC, write phase: response with rsp_data_o = incremented value and rsp_err_o = pslverr_i.
- Back-to-back commands: FSM returns to IDLE for exactly one cycle between commands; minimum 3 cycles per READ/WRITE.
- Latency: a command accepted into an empty, idle block appears in SETUP 2 cycles later.
- No response backpressure: the consumer must always sample rsp_valid_o.
- Reset mid-transfer: psel_o / penable_o drop immediately (asynchronous); the FIFO and any in-flight command are discarded; no response is issued.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - A counter clears on SETUP entry and increments each ACCESS cycle with pready_i = 0.
  - When it reaches TIMEOUT, the transfer terminates: FSM -> IDLE, response with rsp_err_o = 1 and rsp_data_o = 0; for INC, the write phase is skipped.
- Undefined: no counter logic; ACCESS waits indefinitely for pready_i.

Decomposition:
- Package apb_master_pkg:
  - apb_op_t enum (OP_NOP, OP_READ, OP_WRITE, OP_INC).
  - apb_state_t enum (ST_IDLE, ST_SETUP, ST_ACCESS).
  - Packed cmd_t struct {op, addr, wdata}.
- Sub-module apb_cmd_fifo:
  - Synchronous FIFO, parametrised width/depth.
  - Pointers with an extra wrap bit for full/empty detection.
  - Outputs full/empty/count.

Test Plan:
- READ 0xDEAD_CAFE, slave returns 0x1234_5678 with 0 wait states -> psel 2 cycles, penable 1 cycle; rsp_data 0x1234_5678, err 0.
- INC 0x100, slave holds 0xFFFF_FFFF, 2 wait states -> read then write 0x0000_0000 to 0x100; rsp_data 0, err 0; no IDLE cycle between phases.
- Push 5 WRITEs with depth 4 and a slave stalling 10 cycles -> cmd_ready_o low after the 4th enqueue plus the popped head; all 5 complete in order with 5 responses.
- INC with pslverr on the read phase -> no write transfer issued; rsp_err 1.
- APB_TIMEOUT_EN, TIMEOUT=16, pready_i never asserts -> response err 1 after 16 ACCESS cycles; FSM IDLE.
- Assert reset during ACCESS with 2 queued commands -> psel/penable 0 immediately; busy_o 0; no responses after release.
